// File: rtl/shock_alarm_pkg.sv
// -----------------------------------------------------------------------------
// shock_alarm_pkg
//   Shared types and helpers for the multi-channel shock alarm sounder.
//   - alarm_state_e : alarm sequencer states (idle, timed alarm, latched alarm)
//   - alarm_mode_e  : how an alarm ends (timer expiry or operator ack)
//   - MAX_CH        : widest channel vector the helpers understand
//   - lowestSetIndex: priority encoder, lowest set bit wins
// -----------------------------------------------------------------------------
package shock_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALARM = 2'd1,
    ST_LATCH = 2'd2
  } alarm_state_e;

  typedef enum logic {
    MODE_TIMED   = 1'b0,
    MODE_LATCHED = 1'b1
  } alarm_mode_e;

  localparam int MAX_CH = 16;

  // Returns the index of the lowest set bit, or 0 when nothing is set.
  // Callers only use the result when at least one bit is set.
  function automatic logic [3:0] lowestSetIndex(input logic [MAX_CH-1:0] vec);
    logic [3:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (vec[i] && !found) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/shock_alarm_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// shock_debounce
//   One shock channel front end: 2-flop synchroniser, hold-time debounce and
//   rising-edge pulse on the filtered level.
// Ports
//   i_clk   in  1  system clock
//   i_rst   in  1  synchronous reset, active-high
//   i_raw   in  1  raw sensor level, asynchronous to i_clk
//   o_rise  out 1  one-cycle pulse when the filtered level goes 0->1
// -----------------------------------------------------------------------------
module shock_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_rise
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

  logic             r_syncMeta;
  logic             r_syncOut;
  logic             r_filt;
  logic             r_filtDly;
  logic [DEB_W-1:0] r_debCnt;

  // The synchronised level has to disagree with the filtered level for
  // DEBOUNCE_CYC consecutive counts before the filtered level follows it.
  // Any cycle where they agree again throws the partial count away, so a
  // glitch shorter than the hold time never reaches the filtered level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_syncMeta <= 1'b0;
      r_syncOut  <= 1'b0;
      r_filt     <= 1'b0;
      r_filtDly  <= 1'b0;
      r_debCnt   <= '0;
    end else begin
      r_syncMeta <= i_raw;
      r_syncOut  <= r_syncMeta;
      r_filtDly  <= r_filt;
      if (r_syncOut != r_filt) begin
        if (r_debCnt == DEB_W'(DEBOUNCE_CYC)) begin
          r_filt   <= r_syncOut;
          r_debCnt <= '0;
        end else begin
          r_debCnt <= r_debCnt + 1'b1;
        end
      end else begin
        r_debCnt <= '0;
      end
    end
  end

  // A level held high produces a single pulse; a fresh pulse needs the
  // filtered level to fall and rise again.
  assign o_rise = r_filt & ~r_filtDly;

endmodule

// File: rtl/shock_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// shock_alarm_ctrl
//   Multi-channel shock-sensor alarm sounder. Each raw channel is debounced
//   and edge detected; unmasked events start or retrigger a timed alarm that
//   either ends on its own or latches until acknowledged. The buzzer output is
//   a continuous tone or a square-wave beep.
// Ports
//   i_clk        in  1            system clock
//   i_rst        in  1            synchronous reset, active-high
//   i_shock      in  N_CH         raw sensor levels (asynchronous)
//   i_mask       in  N_CH         1 = ignore events on that channel
//   i_latch_mode in  1            0 = timed alarm, 1 = latched until ack
//   i_ack        in  1            single-cycle clear/abort of a running alarm
//   o_sound      out 1            buzzer enable
//   o_busy       out 1            alarm sequencer not idle
//   o_active_ch  out N_CH         channels that fired during the current alarm
//   o_last_ch    out clog2(N_CH)  most recent triggering channel
//   o_event_cnt  out CNT_W        saturating count of cycles carrying events
// -----------------------------------------------------------------------------
module shock_alarm_ctrl
  import shock_alarm_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SOUND_CYC    = 1000,
  parameter int BEEP_HALF    = 0,
  parameter int CNT_W        = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic [N_CH-1:0]                          i_shock,
  input  logic [N_CH-1:0]                          i_mask,
  input  logic                                     i_latch_mode,
  input  logic                                     i_ack,
  output logic                                     o_sound,
  output logic                                     o_busy,
  output logic [N_CH-1:0]                          o_active_ch,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] o_last_ch,
  output logic [CNT_W-1:0]                         o_event_cnt
);

  localparam int LCH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W  = $clog2(SOUND_CYC);
  localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   w_event;
  logic              w_anyEvent;
  logic [MAX_CH-1:0] w_eventPad;
  logic [3:0]        w_lowIdx;

  alarm_state_e      r_state;
  alarm_mode_e       r_mode;
  logic [TMR_W-1:0]  r_timer;
  logic [BEEP_W-1:0] r_beepCnt;
  logic              r_sound;
  logic [N_CH-1:0]   r_activeCh;
  logic [LCH_W-1:0]  r_lastCh;
  logic [CNT_W-1:0]  r_eventCnt;

  // One synchroniser/debouncer per channel.
  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_chan
      shock_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_shock[g]),
        .o_rise (w_rise[g])
      );
    end
  endgenerate

  // Masking only suppresses new events; it never ends an alarm by itself.
  assign w_event    = w_rise & ~i_mask;
  assign w_anyEvent = |w_event;
  assign w_eventPad = MAX_CH'(w_event);
  assign w_lowIdx   = lowestSetIndex(w_eventPad);

  // Alarm sequencer with all outputs registered.
  // Statement order matters: event bookkeeping and the beep advance are
  // written first, so the per-state branches below can override them on
  // alarm entry (beep restart) and on any exit to idle (silence, clear).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_TIMED;
      r_timer    <= '0;
      r_beepCnt  <= '0;
      r_sound    <= 1'b0;
      r_activeCh <= '0;
      r_lastCh   <= '0;
      r_eventCnt <= '0;
    end else begin
      // Events are counted and recorded in every state, including the cycle
      // an ack lands in.
      if (w_anyEvent) begin
        r_lastCh <= LCH_W'(w_lowIdx);
        if (r_eventCnt != {CNT_W{1'b1}}) begin
          r_eventCnt <= r_eventCnt + 1'b1;
        end
      end

      // Tone generation while an alarm is running; a retrigger leaves the
      // beep phase untouched.
      if (r_state != ST_IDLE) begin
        if (BEEP_HALF == 0) begin
          r_sound <= 1'b1;
        end else if (r_beepCnt == BEEP_W'(BEEP_HALF - 1)) begin
          r_beepCnt <= '0;
          r_sound   <= ~r_sound;
        end else begin
          r_beepCnt <= r_beepCnt + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_anyEvent) begin
            r_state    <= ST_ALARM;
            r_timer    <= TMR_W'(SOUND_CYC - 1);
            r_mode     <= alarm_mode_e'(i_latch_mode);
            r_activeCh <= w_event;
            r_beepCnt  <= '0;
            r_sound    <= 1'b1;
          end
        end

        ST_ALARM: begin
          if (i_ack) begin
            r_state    <= ST_IDLE;
            r_activeCh <= '0;
            r_sound    <= 1'b0;
          end else if (w_anyEvent) begin
            r_timer    <= TMR_W'(SOUND_CYC - 1);
            r_activeCh <= r_activeCh | w_event;
          end else if (r_timer == '0) begin
            if (r_mode == MODE_LATCHED) begin
              r_state <= ST_LATCH;
            end else begin
              r_state    <= ST_IDLE;
              r_activeCh <= '0;
              r_sound    <= 1'b0;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end

        ST_LATCH: begin
          if (i_ack) begin
            r_state    <= ST_IDLE;
            r_activeCh <= '0;
            r_sound    <= 1'b0;
          end else begin
            r_activeCh <= r_activeCh | w_event;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_activeCh <= '0;
          r_sound    <= 1'b0;
        end
      endcase
    end
  end

  assign o_sound     = r_sound;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_active_ch = r_activeCh;
  assign o_last_ch   = r_lastCh;
  assign o_event_cnt = r_eventCnt;

endmodule
